// File: rtl/dma_pkg.sv
// Shared DMA definitions: master FSM encoding, AHB-Lite encodings and the
// DMA slave register map used by both the slave and master blocks.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_D = 3'd2,
        ST_WR_A = 3'd3,
        ST_WR_D = 3'd4,
        ST_FIN  = 3'd5
    } dma_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [31:0] DMA_SRC_ADDR_REG  = 32'h4000_0010;
    localparam logic [31:0] DMA_DEST_ADDR_REG = 32'h4000_0060;
    localparam logic [31:0] DMA_LEN_REG       = 32'h4000_0090;

    // Byte pointer to word-aligned bus address.
    function automatic logic [31:0] word_addr(input logic [31:0] ptr);
        return ptr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/dma_master.sv
// Single-channel AHB-Lite DMA master: copies transfer_length_reg words from
// src to dest as alternating single read/write transfers, one word at a time.
module dma_master
    import dma_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             hclk,
    input  logic             hreset_n,
    input  logic             dma_start,
    input  logic             count_pulldown,
    input  logic [31:0]      src_addr_reg,
    input  logic [31:0]      dest_addr_reg,
    input  logic [LEN_W-1:0] transfer_length_reg,
    output logic [31:0]      haddr_o,
    output logic [1:0]       htrans_o,
    output logic             hwrite_o,
    output logic [2:0]       hsize_o,
    output logic [2:0]       hburst_o,
    output logic [3:0]       hprot_o,
    output logic             hmastlock_o,
    output logic [31:0]      hwdata_o,
    input  logic [31:0]      hrdata_i,
    input  logic             hready_i,
    input  logic [1:0]       hresp_i,
    output logic             done,
    output logic             busy,
    output logic             error
);

    dma_state_e       state_q, state_d;
    logic [31:0]      rd_ptr_q, wr_ptr_q, data_q, hwdata_q;
    logic [LEN_W-1:0] remaining_q;
    logic             error_q;
    logic             start, beat_ok, beat_err;

    assign start    = (state_q == ST_IDLE) && count_pulldown && dma_start;
    assign beat_ok  = hready_i && (hresp_i == HRESP_OKAY);
    // ERROR is acted on in its first (hready low) cycle.
    assign beat_err = (hresp_i == HRESP_ERROR);

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = (transfer_length_reg == '0) ? ST_FIN : ST_RD_A;
            ST_RD_A: if (hready_i) state_d = ST_RD_D;
            ST_RD_D: begin
                if (beat_err)     state_d = ST_FIN;
                else if (beat_ok) state_d = ST_WR_A;
            end
            ST_WR_A: if (hready_i) state_d = ST_WR_D;
            ST_WR_D: begin
                if (beat_err)     state_d = ST_FIN;
                else if (beat_ok) state_d = (remaining_q == LEN_W'(1)) ? ST_FIN : ST_RD_A;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointers, word count, data and error flag.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            hwdata_q    <= '0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rd_ptr_q    <= src_addr_reg;
                        wr_ptr_q    <= dest_addr_reg;
                        remaining_q <= transfer_length_reg;
                        error_q     <= 1'b0;
                    end
                end
                ST_RD_D: begin
                    if (beat_err)     error_q <= 1'b1;
                    else if (beat_ok) data_q  <= hrdata_i;
                end
                ST_WR_A: if (hready_i) hwdata_q <= data_q;
                ST_WR_D: begin
                    if (beat_err) begin
                        error_q <= 1'b1;
                    end else if (beat_ok) begin
                        rd_ptr_q    <= rd_ptr_q + 32'd4;
                        wr_ptr_q    <= wr_ptr_q + 32'd4;
                        remaining_q <= remaining_q - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        haddr_o  = '0;
        htrans_o = HTRANS_IDLE;
        hwrite_o = 1'b0;
        done     = (state_q == ST_FIN);
        busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_RD_A: begin
                haddr_o  = word_addr(rd_ptr_q);
                htrans_o = HTRANS_NONSEQ;
            end
            ST_WR_A: begin
                haddr_o  = word_addr(wr_ptr_q);
                htrans_o = HTRANS_NONSEQ;
                hwrite_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign hwdata_o    = hwdata_q;
    assign error       = error_q;
    assign hsize_o     = HSIZE_WORD;
    assign hburst_o    = HBURST_SINGLE;
    assign hprot_o     = HPROT_DATA;
    assign hmastlock_o = 1'b0;

endmodule

// File: tb/tb_dma_master.sv
// Scoreboard bench for dma_master: a behavioural AHB slave/memory, a transfer
// reference model that queues expected bus traffic, and a decoupled bus monitor.
`timescale 1ns/1ps
module tb_dma_master;
    import dma_pkg::*;

    localparam int LEN_W = 4;

    logic             hclk = 1'b0;
    logic             hreset_n;
    logic             dma_start, count_pulldown;
    logic [31:0]      src_addr_reg, dest_addr_reg;
    logic [LEN_W-1:0] transfer_length_reg;
    logic [31:0]      haddr_o, hwdata_o, hrdata_i;
    logic [1:0]       htrans_o, hresp_i;
    logic             hwrite_o, hmastlock_o, hready_i;
    logic [2:0]       hsize_o, hburst_o;
    logic [3:0]       hprot_o;
    logic             done, busy, error;

    dma_master #(.LEN_W(LEN_W)) dut (
        .hclk(hclk), .hreset_n(hreset_n), .dma_start(dma_start),
        .count_pulldown(count_pulldown), .src_addr_reg(src_addr_reg),
        .dest_addr_reg(dest_addr_reg), .transfer_length_reg(transfer_length_reg),
        .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o),
        .hsize_o(hsize_o), .hburst_o(hburst_o), .hprot_o(hprot_o),
        .hmastlock_o(hmastlock_o), .hwdata_o(hwdata_o), .hrdata_i(hrdata_i),
        .hready_i(hready_i), .hresp_i(hresp_i), .done(done), .busy(busy), .error(error)
    );

    always #5 hclk = ~hclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Expected bus traffic: {hwrite, haddr} per accepted address phase, and
    // {addr, data} per completed write.
    logic [32:0] exp_addr_q[$];
    logic [63:0] exp_wr_q[$];

    // Slave configuration and data-phase state.
    logic [31:0] salt;
    int  stall_pct = 0, wait_n = 0, err_rd_idx = -1, err_wr_idx = -1;
    int  rd_cnt = 0, wr_cnt = 0;
    bit  slave_flush = 1'b0;
    bit  dp_active = 1'b0, dp_write = 1'b0, dp_err = 1'b0, dp_errstage = 1'b0;
    int  dp_wait = 0;
    logic [31:0] dp_addr = '0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ salt;
    endfunction

    // AHB slave: samples mid-cycle, drives the next cycle just after the edge.
    initial begin
        bit s_acc, s_wr, s_end;
        logic [31:0] s_addr;
        hready_i = 1'b1;
        hresp_i  = HRESP_OKAY;
        hrdata_i = '0;
        forever begin
            @(negedge hclk);
            s_acc  = hreset_n && (htrans_o == HTRANS_NONSEQ) && hready_i;
            s_addr = haddr_o;
            s_wr   = hwrite_o;
            s_end  = dp_active && hready_i;
            @(posedge hclk);
            #1;
            if (slave_flush) begin
                dp_active   = 1'b0;
                slave_flush = 1'b0;
                s_acc       = 1'b0;
                s_end       = 1'b0;
            end
            if (s_end) dp_active = 1'b0;
            if (s_acc) begin
                dp_active   = 1'b1;
                dp_addr     = s_addr;
                dp_write    = s_wr;
                dp_wait     = wait_n;
                dp_errstage = 1'b0;
                if (s_wr) begin dp_err = (wr_cnt == err_wr_idx); wr_cnt++; end
                else      begin dp_err = (rd_cnt == err_rd_idx); rd_cnt++; end
            end
            if (dp_active) begin
                if (dp_wait > 0) begin
                    hready_i = 1'b0; hresp_i = HRESP_OKAY; dp_wait--;
                end else if (dp_err) begin
                    hready_i = dp_errstage; hresp_i = HRESP_ERROR; dp_errstage = 1'b1;
                end else begin
                    hready_i = 1'b1; hresp_i = HRESP_OKAY;
                    hrdata_i = dp_write ? $urandom : mem_val(dp_addr);
                end
            end else begin
                hready_i = ($urandom_range(0, 99) >= stall_pct);
                hresp_i  = HRESP_OKAY;
                hrdata_i = $urandom;
            end
        end
    end

    // Bus monitor: pops the scoreboard whenever the DUT presents traffic.
    initial begin
        bit p_stall;
        logic [31:0] p_addr;
        logic p_wr;
        logic [32:0] ea;
        logic [63:0] ew;
        p_stall = 1'b0;
        forever begin
            @(negedge hclk);
            if (!hreset_n) begin
                p_stall = 1'b0;
            end else begin
                if (p_stall) begin
                    check("hold_htrans", 64'(htrans_o), 64'(HTRANS_NONSEQ));
                    check("hold_haddr", 64'(haddr_o), 64'(p_addr));
                    check("hold_hwrite", 64'(hwrite_o), 64'(p_wr));
                end
                p_stall = (htrans_o == HTRANS_NONSEQ) && !hready_i;
                p_addr  = haddr_o;
                p_wr    = hwrite_o;
                if (htrans_o == HTRANS_NONSEQ && hready_i) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_nonseq actual=0x%0h expected=no_transfer", {hwrite_o, haddr_o});
                    end else begin
                        ea = exp_addr_q.pop_front();
                        check("bus_addr", 64'({hwrite_o, haddr_o}), 64'(ea));
                    end
                end
                if (dp_active && dp_write && hready_i && hresp_i == HRESP_OKAY) begin
                    if (exp_wr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write actual=0x%0h expected=no_write", {dp_addr, hwdata_o});
                    end else begin
                        ew = exp_wr_q.pop_front();
                        check("write_data", {dp_addr, hwdata_o}, ew);
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_haddr"}, 64'(haddr_o), 64'd0);
        check({tag, "_htrans"}, 64'(htrans_o), 64'(HTRANS_IDLE));
        check({tag, "_hwrite"}, 64'(hwrite_o), 64'd0);
        check({tag, "_hwdata"}, 64'(hwdata_o), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
    endtask

    // Reference model: the words that must move, and the cycle done must appear
    // in (start cycle = 1), plus one per wait state.
    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int e_r, input int e_w, input bit glitch, input bit rst_wr,
                            input string tag);
        int exp_done, k, stalls, busy_bad;
        bit exp_err, got;
        logic [31:0] a_r, a_w;
        salt = $urandom;
        for (int i = 0; i < len; i++) begin
            a_r = (src + 32'(4 * i)) & 32'hFFFF_FFFC;
            a_w = (dst + 32'(4 * i)) & 32'hFFFF_FFFC;
            exp_addr_q.push_back({1'b0, a_r});
            if (i == e_r) break;
            exp_addr_q.push_back({1'b1, a_w});
            if (i == e_w) break;
            exp_wr_q.push_back({a_w, mem_val(a_r)});
        end
        exp_err = (e_r >= 0) || (e_w >= 0);
        if (len == 0)     exp_done = 2;
        else if (e_r >= 0) exp_done = 4 * e_r + 4;
        else if (e_w >= 0) exp_done = 4 * e_w + 6;
        else              exp_done = 4 * len + 2;
        err_rd_idx = e_r;
        err_wr_idx = e_w;
        rd_cnt = 0;
        wr_cnt = 0;

        @(negedge hclk);
        src_addr_reg        = src;
        dest_addr_reg       = dst;
        transfer_length_reg = LEN_W'(len);
        dma_start           = 1'b1;
        count_pulldown      = 1'b1;
        check({tag, "_busy_start"}, 64'(busy), 64'd0);
        k = 1; stalls = 0; busy_bad = 0; got = 1'b0;
        while (!got && k < 400) begin
            @(negedge hclk);
            k++;
            if (k == 2) count_pulldown = 1'b0;
            if (glitch && k == 4) begin
                count_pulldown = 1'b1; src_addr_reg = 32'hDEAD_0000; transfer_length_reg = LEN_W'(1);
            end
            if (glitch && k == 5) count_pulldown = 1'b0;
            if (rst_wr && htrans_o == HTRANS_NONSEQ && hwrite_o) begin
                #2;
                hreset_n    = 1'b0;
                slave_flush = 1'b1;
                #1;
                check_reset_outputs({tag, "_async"});
                exp_addr_q.delete();
                exp_wr_q.delete();
                repeat (2) @(negedge hclk);
                check({tag, "_no_done_in_rst"}, 64'(done), 64'd0);
                hreset_n = 1'b1;
                @(negedge hclk);
                check({tag, "_no_done_after_rst"}, 64'(done), 64'd0);
                check({tag, "_idle_after_rst"}, 64'(busy), 64'd0);
                return;
            end
            if (done) got = 1'b1;
            else begin
                if (!busy) busy_bad++;
                if (!hready_i && hresp_i == HRESP_OKAY) stalls++;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=no_done expected=done_by_cycle_%0d", tag, exp_done + stalls);
            return;
        end
        check({tag, "_done_cycle"}, 64'(k), 64'(exp_done + stalls));
        check({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
        check({tag, "_busy_fin"}, 64'(busy), 64'd1);
        check({tag, "_htrans_fin"}, 64'(htrans_o), 64'(HTRANS_IDLE));
        @(negedge hclk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_busy_idle"}, 64'(busy), 64'd0);
        check({tag, "_error"}, 64'(error), 64'(exp_err));
        check({tag, "_addr_left"}, 64'(exp_addr_q.size()), 64'd0);
        check({tag, "_wr_left"}, 64'(exp_wr_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        hreset_n            = 1'b0;
        dma_start           = 1'b0;
        count_pulldown      = 1'b0;
        src_addr_reg        = '0;
        dest_addr_reg       = '0;
        transfer_length_reg = '0;
        #1;
        check_reset_outputs("rst");
        check("hsize", 64'(hsize_o), 64'(3'b010));
        check("hburst", 64'(hburst_o), 64'(3'b000));
        check("hprot", 64'(hprot_o), 64'(4'b0011));
        check("hmastlock", 64'(hmastlock_o), 64'd0);
        repeat (2) @(negedge hclk);
        hreset_n = 1'b1;

        stall_pct = 0; wait_n = 0;
        run_xfer(32'h100, 32'h200, 3, -1, -1, 1'b0, 1'b0, "basic");
        run_xfer(32'h300, 32'h400, 0, -1, -1, 1'b0, 1'b0, "len0");
        wait_n = 2;
        run_xfer(32'h500, 32'h600, 2, -1, -1, 1'b0, 1'b0, "waits");
        wait_n = 0;
        run_xfer(32'h700, 32'h800, 4, 1, -1, 1'b0, 1'b0, "rderr");
        run_xfer(32'hFFFF_FFFC, 32'h900, 2, -1, -1, 1'b1, 1'b0, "wrap");
        run_xfer(32'hA00, 32'hB00, 3, -1, 2, 1'b0, 1'b0, "wrerr");
        run_xfer(32'hC04, 32'hD08, 3, -1, -1, 1'b0, 1'b0, "pre_rst");
        run_xfer(32'hE00, 32'hF00, 3, -1, -1, 1'b0, 1'b1, "rst_wr");
        run_xfer(32'h1000, 32'h2000, 2, -1, -1, 1'b0, 1'b0, "post_rst");

        @(negedge hclk);
        dma_start = 1'b0;
        count_pulldown = 1'b1;
        @(negedge hclk);
        count_pulldown = 1'b0;
        repeat (3) @(negedge hclk);
        check("nostart_busy", 64'(busy), 64'd0);
        check("nostart_done", 64'(done), 64'd0);

        for (int t = 0; t < 16; t++) begin
            int len, er, ew;
            len = $urandom_range(0, 15);
            stall_pct = $urandom_range(0, 40);
            wait_n = $urandom_range(0, 2);
            er = -1;
            ew = -1;
            if (len > 0 && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) er = $urandom_range(0, len - 1);
                else                           ew = $urandom_range(0, len - 1);
            end
            run_xfer($urandom, $urandom, len, er, ew, 1'b0, 1'b0, "rnd");
        end

        repeat (2) @(negedge hclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_master.md
DMA_MASTER -- requirements
Module: dma_master

Interface
REQ-001 Parameter: LEN_W, 4, width of transfer_length_reg and internal word counter.
REQ-002 hclk  in  1  single clock; all state on rising edge.
REQ-003 hreset_n  in  1  reset, asynchronous, active-low.
REQ-004 dma_start  in  1  level enable from DMA slave (source address programmed).
REQ-005 count_pulldown  in  1  one-cycle pulse from DMA slave; length register just written.
REQ-006 src_addr_reg  in  32  source byte address.
REQ-007 dest_addr_reg  in  32  destination byte address.
REQ-008 transfer_length_reg  in  LEN_W  number of 32-bit words to move.
REQ-009 haddr_o  out  32  AHB-Lite master address.
REQ-010 htrans_o  out  2  IDLE (00) or NONSEQ (10) only.
REQ-011 hwrite_o, hsize_o[2:0], hburst_o[2:0], hprot_o[3:0], hmastlock_o  out  AHB control; hsize=010, hburst=000, hprot=0011, hmastlock=0, all constant.
REQ-012 hwdata_o  out  32  write data; hrdata_i  in  32  read data.
REQ-013 hready_i  in  1; hresp_i  in  2  AHB response (00 OKAY, 01 ERROR).
REQ-014 done  out  1  one-cycle completion pulse, wired to DMA slave done.
REQ-015 busy  out  1  high in every state except IDLE; error  out  1  sticky bus-error flag.

Function
REQ-016 States SHALL be IDLE, RD_A, RD_D, WR_A, WR_D, FIN.
REQ-017 Start = count_pulldown & dma_start in IDLE; start in any other state SHALL be ignored.
REQ-018 On start: latch rd_ptr=src_addr_reg, wr_ptr=dest_addr_reg, remaining=transfer_length_reg, clear error; go RD_A, or FIN if length is 0 (no bus traffic).
REQ-019 RD_A: haddr_o={rd_ptr[31:2],2'b00}, htrans_o=NONSEQ, hwrite_o=0; hready_i=1 -> RD_D, else hold all outputs.
REQ-020 RD_D: htrans_o=IDLE; hready_i=1 and hresp_i=OKAY -> capture hrdata_i into data register, go WR_A.
REQ-021 WR_A: haddr_o={wr_ptr[31:2],2'b00}, htrans_o=NONSEQ, hwrite_o=1; hready_i=1 -> WR_D.
REQ-022 WR_D: htrans_o=IDLE, hwdata_o=data register; hready_i=1 and OKAY -> rd_ptr+=4, wr_ptr+=4, remaining-=1; next FIN if remaining was 1, else RD_A.
REQ-023 Pointers SHALL wrap modulo 2^32 with no carry into other state.
REQ-024 hresp_i=ERROR in RD_D or WR_D (first cycle, hready_i=0) SHALL set error and go FIN on the next edge; htrans_o stays IDLE.
REQ-025 FIN: done=1 for exactly one cycle, then IDLE; busy deasserts on entry to IDLE.
REQ-026 Transfer of N words SHALL take 4N+2 cycles from start to done with zero wait states; each wait state adds one cycle.
REQ-027 hwdata_o SHALL hold last written value outside WR_D; htrans_o SHALL be IDLE in IDLE, FIN, and all data states.

Reset
REQ-028 hreset_n low SHALL force IDLE immediately, including mid-transfer; no completion pulse.
REQ-029 Reset values: haddr_o=0, htrans_o=IDLE, hwrite_o=0, hwdata_o=0, done=0, busy=0, error=0, pointers/counter/data=0.

Structure
REQ-030 Shared package dma_pkg SHALL hold the state encoding, HTRANS/HSIZE/HBURST/HRESP constants, and the DMA register-map addresses 0x40000010/0x40000060/0x40000090 used by both slave and master.
REQ-031 Single module; no sub-module is natural; the FSM, pointers, and data register remain in dma_master.

Verification
REQ-032 src=0x100, dst=0x200, len=3, zero wait -> reads 0x100/0x104/0x108 each followed by a write of the same data to 0x200/0x204/0x208; done high at cycle 14 after start.
REQ-033 len=0 with start -> htrans_o stays IDLE, done pulses one cycle after start, busy high for one cycle.
REQ-034 len=2, slave inserts 2 wait states on each data phase -> address/control held stable while hready_i=0; done at cycle 18.
REQ-035 ERROR response on the second read of len=4 -> no further NONSEQ, error=1, done pulses, remaining writes skipped.
REQ-036 src=0xFFFFFFFC, len=2 -> second read address 0x00000000; count_pulldown pulsed while busy is ignored.
REQ-037 hreset_n asserted in WR_A -> outputs at reset values asynchronously; a subsequent start runs a clean transfer.
